regfile_master: RTL and testbench
=================================

# regfile_master

Command-driven initiator for the 8-entry × 8-bit synchronous register-file memory (ports `din`/`addr`/`wr`/`rd`/`dout`/`error`). It accepts single or burst read/write commands over a valid/ready handshake and drives the memory strobes. Read data returns on a back-pressurable response stream. The block guarantees `wr` and `rd` are never asserted together, and reports any `error` the memory raises during a command.

## Interface
- `DW`, 8, data width; matches memory word width.
- `AW`, 3, address width; memory depth is 2^AW.

- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_op`  in  1  0 = read burst, 1 = write burst.
- `cmd_addr`  in  AW  start address.
- `cmd_len`  in  AW  burst length minus one (0 → 1 word, 7 → 8 words).
- `cmd_wdata`  in  DW  first write value; word i is written with `cmd_wdata + i`.
- `mem_din`  out  DW  to memory `din`.
- `mem_addr`  out  AW  to memory `addr`.
- `mem_wr`  out  1  to memory `wr`.
- `mem_rd`  out  1  to memory `rd`.
- `mem_dout`  in  DW  from memory `dout`; valid the cycle after `rd` is sampled.
- `mem_error`  in  1  from memory `error`.
- `rsp_valid`  out  1  read word available.
- `rsp_ready`  in  1  consumer accepts read word.
- `rsp_data`  out  DW  read word.
- `rsp_last`  out  1  qualifies final word of a read burst.
- `done`  out  1  one-cycle pulse at command completion.
- `err`  out  1  sticky: memory error seen during current/last command.

## Operation
- Command latch: on `cmd_valid && cmd_ready` at a rising edge, latch op, addr, len, wdata. Clear word counter `cnt` and `err`.
- States are IDLE, WR, RD_ISSUE, RD_CAP, RD_RSP and DONE.
- IDLE: `cmd_ready`=1, all memory strobes 0. Accept → WR (op=1) or RD_ISSUE (op=0).
- WR: `mem_wr`=1, `mem_addr`=(addr+cnt) mod 2^AW, `mem_din`=(wdata+cnt) mod 2^DW. Each cycle `cnt`++. When cnt==len → DONE.
- RD_ISSUE: `mem_rd`=1, `mem_addr`=(addr+cnt) mod 2^AW for one cycle → RD_CAP.
- RD_CAP: no strobes. At the edge, register `mem_dout` into `rsp_data`, set `rsp_valid`, and set `rsp_last`=(cnt==len) → RD_RSP.
- RD_RSP: hold `rsp_valid`/`rsp_data`/`rsp_last` stable until `rsp_ready`. On handshake, clear `rsp_valid`. If last → DONE, else `cnt`++ → RD_ISSUE.
- DONE: `done`=1 for one cycle, `cmd_ready`=0 → IDLE.
- Outside the states listed above, `mem_din`=0, `mem_addr`=0, `mem_wr`=0 and `mem_rd`=0.
- `mem_wr && mem_rd` is never 1; this is an invariant.
- Error capture: `mem_error`=1 in any cycle outside IDLE sets `err`. `err` holds through `done` and until the next command is accepted. Read data is still returned; the burst is not aborted.
- Address wraps modulo 2^AW (addr 6, len 3 → 6, 7, 0, 1). Write data wraps modulo 2^DW.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0); no queuing.

## Timing
- Reset (asynchronous, immediate): state IDLE; `cnt`=0; `mem_*` outputs 0; `rsp_valid`=0, `rsp_data`=0, `rsp_last`=0, `done`=0, `err`=0.
- `cmd_ready` goes 1 in the first cycle after `resetn` deasserts.
- Reset mid-burst: outputs drop the same instant, the burst is abandoned, and no `done` is produced.
- Write burst of N words:
  - Accept edge E0; `mem_wr` is high for cycles E0+1 … E0+N.
  - `done` is high in cycle E0+N+1.
  - `cmd_ready` is high again in cycle E0+N+2.
- Read word with `rsp_ready` held 1: issue cycle, capture cycle, then `rsp_valid` for one cycle. Throughput is 3 cycles/word.
- First `rsp_valid` appears 3 cycles after the accept edge.
- `done` appears the cycle after the last response handshake.
- Backpressure: no new `mem_rd` while `rsp_valid` is pending. Memory reads are therefore never lost or duplicated.

## Test plan
- Reset:
  - Stimulus: assert `resetn`=0, then release.
  - Required response: all outputs 0 during reset; `cmd_ready`=1 the first cycle after release; `mem_wr`=`mem_rd`=0.
- Single write:
  - Stimulus: op=1, addr=3, len=0, wdata=0xA5.
  - Required response: exactly one cycle with `mem_wr`=1, `mem_addr`=3, `mem_din`=0xA5; `done` the next cycle; `err`=0.
- Wrapping write burst:
  - Stimulus: op=1, addr=6, len=3, wdata=0xFE.
  - Required response: writes (6,0xFE), (7,0xFF), (0,0x00), (1,0x01) on consecutive cycles, then one `done`.
- Read burst with backpressure:
  - Stimulus: after the wrapping write, op=0, addr=6, len=3; `rsp_ready` toggles 0/1.
  - Required response: `rsp_data` = 0xFE, 0xFF, 0x00, 0x01 in order; `rsp_last` only on 0x01; data stable while stalled; `mem_rd` never high while `rsp_valid`=1; `mem_wr`&`mem_rd` never both 1.
- Memory error:
  - Stimulus: force `mem_error`=1 for one cycle during a read burst.
  - Required response: burst completes; `done` with `err`=1; `err` clears when the next command is accepted.
- Reset mid-operation:
  - Stimulus: drop `resetn` during word 2 of an 8-word write burst.
  - Required response: `mem_wr` low immediately; no `done`; a new single read after release returns the correct memory content.

Source files
------------

// File: rtl/regfile_master.sv
// regfile_master: command-driven initiator for an 8x8 synchronous register file.
// Accepts single/burst read and write commands over valid/ready, drives the
// memory strobes, returns read words on a back-pressurable response stream,
// and records any memory error seen while a command is in flight.
module regfile_master #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_wdata,
  output logic [DW-1:0] mem_din,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_error,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_CAP,
    S_RD_RSP,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_len;
  logic [DW-1:0] r_wdata;
  logic [AW-1:0] r_cnt;
  logic          r_cmd_ready;
  logic [DW-1:0] r_mem_din;
  logic [AW-1:0] r_mem_addr;
  logic          r_mem_wr;
  logic          r_mem_rd;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_last;
  logic          r_done;
  logic          r_err;

  // Next word's counter, address and write data; address and data wrap
  // naturally through the truncating widths.
  logic [AW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_addr_nxt;
  logic [DW-1:0] w_din_nxt;
  logic          w_at_last;

  assign w_cnt_nxt  = r_cnt + 1'b1;
  assign w_addr_nxt = r_addr + w_cnt_nxt;
  assign w_din_nxt  = r_wdata + DW'(w_cnt_nxt);
  assign w_at_last  = (r_cnt == r_len);

  // Control FSM; all memory strobes and response outputs are registered so
  // that they change only at clock edges (or immediately on reset).
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would make later lines see new values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_mem_din   <= '0;
      r_mem_addr  <= '0;
      r_mem_wr    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      // Sticky error: any memory error while a command is in flight.
      if (r_state != S_IDLE && mem_error) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_addr      <= cmd_addr;
            r_len       <= cmd_len;
            r_wdata     <= cmd_wdata;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_mem_addr  <= cmd_addr;
            if (cmd_op) begin
              r_state   <= S_WR;
              r_mem_wr  <= 1'b1;
              r_mem_din <= cmd_wdata;
            end else begin
              r_state   <= S_RD_ISSUE;
              r_mem_rd  <= 1'b1;
            end
          end
        end

        S_WR: begin
          if (w_at_last) begin
            r_state    <= S_DONE;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_done     <= 1'b1;
          end else begin
            r_cnt      <= w_cnt_nxt;
            r_mem_addr <= w_addr_nxt;
            r_mem_din  <= w_din_nxt;
          end
        end

        S_RD_ISSUE: begin
          r_state    <= S_RD_CAP;
          r_mem_rd   <= 1'b0;
          r_mem_addr <= '0;
        end

        S_RD_CAP: begin
          r_state     <= S_RD_RSP;
          r_rsp_data  <= mem_dout;
          r_rsp_valid <= 1'b1;
          r_rsp_last  <= w_at_last;
        end

        S_RD_RSP: begin
          // Next read is issued only after the pending word is taken.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            if (r_rsp_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_RD_ISSUE;
              r_cnt      <= w_cnt_nxt;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_addr_nxt;
            end
          end
        end

        S_DONE: begin
          r_state     <= S_IDLE;
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          r_mem_wr    <= 1'b0;
          r_mem_rd    <= 1'b0;
          r_mem_addr  <= '0;
          r_mem_din   <= '0;
          r_rsp_valid <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign mem_din   = r_mem_din;
  assign mem_addr  = r_mem_addr;
  assign mem_wr    = r_mem_wr;
  assign mem_rd    = r_mem_rd;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_last  = r_rsp_last;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_regfile_master.sv
// tb_regfile_master: directed bench for regfile_master with a behavioural
// register-file memory, a read-response scoreboard queue and per-cycle
// protocol invariant checks.
module tb_regfile_master;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk;
  logic          resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] mem_din;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic          mem_rd;
  logic [DW-1:0] mem_dout;
  logic          mem_error;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_err = 0;

  // Expected read responses: {last, data}
  logic [DW:0] exp_q[$];

  regfile_master #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_wdata (cmd_wdata),
    .mem_din   (mem_din),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_rd    (mem_rd),
    .mem_dout  (mem_dout),
    .mem_error (mem_error),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural synchronous register file (not reset by resetn).
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    if (mem_rd) mem_dout <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle invariants and response stability while stalled.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          prev_last  = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      check("wr_rd_exclusive", 32'(mem_wr & mem_rd), 32'd0);
      check("no_rd_while_rsp", 32'(mem_rd & rsp_valid), 32'd0);
      if (prev_stall) begin
        check("stall_valid_held", 32'(rsp_valid), 32'd1);
        check("stall_data_held", 32'({rsp_last, rsp_data}), 32'({prev_last, prev_data}));
      end
      prev_stall = rsp_valid & ~rsp_ready;
      prev_data  = rsp_data;
      prev_last  = rsp_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Offer a command and wait (bounded) for its acceptance edge; returns #1
  // after the accept edge, i.e. in cycle E0+1.
  task automatic send_cmd(input logic op, input logic [AW-1:0] a,
                          input logic [AW-1:0] len, input logic [DW-1:0] wd);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_wdata = wd;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check("cmd_accept_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Check an N-word write burst cycle by cycle, then done and cmd_ready.
  task automatic check_write(input logic [AW-1:0] a, input int n, input logic [DW-1:0] wd);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int i = 0; i < n; i++) begin
      ea = a + AW'(i);
      ed = wd + DW'(i);
      check("wr_strobe", 32'({mem_wr, mem_rd}), 32'b10);
      check("wr_addr", 32'(mem_addr), 32'(ea));
      check("wr_data", 32'(mem_din), 32'(ed));
      check("wr_no_done", 32'(done), 32'd0);
      tick();
    end
    check("wr_end_strobe", 32'(mem_wr), 32'd0);
    check("wr_done", 32'(done), 32'd1);
    check("wr_err", 32'(err), 32'd0);
    tick();
    check("wr_done_pulse", 32'(done), 32'd0);
    check("wr_ready_again", 32'(cmd_ready), 32'd1);
  endtask

  // Drain read responses against the scoreboard. toggle: rsp_ready
  // alternates 0/1; otherwise held 1 and first-response latency is checked.
  // err_cyc: cycle in which mem_error is pulsed (-1 for none).
  task automatic run_read(input bit toggle, input int err_cyc, input logic exp_err);
    int  first = -1;
    bit  fin   = 1'b0;
    logic [DW:0] e;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      rsp_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      mem_error = (cyc == err_cyc);
      @(negedge clk);
      if (rsp_valid && first < 0) first = cyc;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rsp_word", 32'({rsp_last, rsp_data}), 32'(e));
        end else begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end
        if (exp_q.size() == 0) fin = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    mem_error = 1'b0;
    rsp_ready = 1'b0;
    check("rsp_all_seen", 32'(exp_q.size()), 32'd0);
    if (!toggle) check("first_rsp_latency", 32'(first), 32'd2);
    check("rd_done", 32'(done), 32'd1);
    check("rd_err", 32'(err), 32'(exp_err));
    check("rd_valid_clear", 32'(rsp_valid), 32'd0);
    tick();
    check("rd_done_pulse", 32'(done), 32'd0);
    check("rd_err_held", 32'(err), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_wdata = '0;
    mem_error = 1'b0;
    rsp_ready = 1'b0;

    // Reset: everything low while held, ready the first cycle after release.
    #22;
    check("rst_ctrl_outs", 32'({cmd_ready, mem_wr, mem_rd, rsp_valid, rsp_last, done, err}), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("rst_ready_after", 32'(cmd_ready), 32'd1);
    check("rst_strobes_after", 32'({mem_wr, mem_rd}), 32'd0);

    // Single write.
    send_cmd(1'b1, 3'd3, 3'd0, 8'hA5);
    check_write(3'd3, 1, 8'hA5);

    // Wrapping write burst: (6,FE) (7,FF) (0,00) (1,01).
    send_cmd(1'b1, 3'd6, 3'd3, 8'hFE);
    check_write(3'd6, 4, 8'hFE);

    // Read back with backpressure.
    exp_q.push_back({1'b0, 8'hFE});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h01});
    send_cmd(1'b0, 3'd6, 3'd3, 8'h00);
    run_read(1'b1, -1, 1'b0);

    // Read with a memory error mid-burst: completes, err reported.
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b1, 8'h01});
    send_cmd(1'b0, 3'd0, 3'd1, 8'h00);
    run_read(1'b0, 3, 1'b1);

    // 8-word write, reset during word 2; err cleared by the accept.
    send_cmd(1'b1, 3'd0, 3'd7, 8'h10);
    check("err_cleared_on_accept", 32'(err), 32'd0);
    check("mid_w0", 32'({mem_wr, mem_addr, mem_din}), 32'({1'b1, 3'd0, 8'h10}));
    tick();
    check("mid_w1", 32'({mem_wr, mem_addr, mem_din}), 32'({1'b1, 3'd1, 8'h11}));
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_wr_low", 32'({mem_wr, mem_rd}), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_done", 32'(done), 32'd0);
      check("post_rst_no_wr", 32'(mem_wr), 32'd0);
    end
    // Word 0 landed, word 1 must not have been written.
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h01});
    send_cmd(1'b0, 3'd0, 3'd1, 8'h00);
    run_read(1'b0, -1, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
